// File: rtl/flash_read_arbiter_pkg.sv
// Shared definitions for the two-requester SPI flash read arbiter:
// opcode, sequencer states and slot tick positions.
package flash_read_arbiter_pkg;

    localparam logic [7:0] FLASH_READ  = 8'h03;
    localparam int         TICK_STROBE = 0;
    localparam int         TICK_SAMPLE = 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GAP,
        S_CMD,
        S_A2,
        S_A1,
        S_A0,
        S_DATA,
        S_HOLD,
        S_END
    } state_t;

    // Chip select is low from the first command slot until the last byte is handed off.
    function automatic logic cs_asserted(input state_t s);
        return (s == S_CMD) || (s == S_A2) || (s == S_A1) || (s == S_A0) ||
               (s == S_DATA) || (s == S_HOLD);
    endfunction

endpackage

// File: rtl/flash_read_arbiter_spi.sv
// SPI mode-0 byte engine: a tx or rx strobe starts one 8-bit exchange that is
// clocked out over 16 ce ticks, MSB first; o_q holds the last received byte.
module flash_read_arbiter_spi (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_ce,
    input  logic       i_tx,
    input  logic       i_rx,
    input  logic [7:0] i_d,
    output logic [7:0] o_q,
    output logic       o_ck,
    output logic       o_mosi,
    input  logic       i_miso
);

    logic [4:0] r_cnt;
    logic       r_ck;
    logic [7:0] r_txsr;
    logic [7:0] r_rxsr;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_ck   <= 1'b0;
            r_txsr <= '0;
            r_rxsr <= '0;
        end else if (i_tx || i_rx) begin
            // A receive-only exchange shifts out zeros.
            r_cnt  <= 5'd16;
            r_ck   <= 1'b0;
            r_txsr <= i_tx ? i_d : 8'h00;
        end else if (i_ce && (r_cnt != 5'd0)) begin
            r_cnt <= r_cnt - 5'd1;
            if (!r_ck) begin
                r_ck   <= 1'b1;
                r_rxsr <= {r_rxsr[6:0], i_miso};
            end else begin
                r_ck   <= 1'b0;
                r_txsr <= {r_txsr[6:0], 1'b0};
            end
        end
    end

    assign o_q    = r_rxsr;
    assign o_ck   = r_ck;
    assign o_mosi = r_txsr[7];

endmodule

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing the SPI flash between a boot/config reader and a
// ROM loader: issues READ + 24-bit address, then streams bytes with back-pressure.
module flash_read_arbiter
    import flash_read_arbiter_pkg::*;
#(
    parameter int SLOT = 16,
    parameter int GAP  = 14,
    parameter int LENW = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            pe,
    input  logic            ne,
    input  logic [1:0]      req,
    input  logic [23:0]     addr0,
    input  logic [LENW-1:0] len0,
    input  logic [23:0]     addr1,
    input  logic [LENW-1:0] len1,
    output logic [1:0]      gnt,
    output logic            busy,
    output logic [7:0]      q,
    output logic            valid,
    input  logic            ready,
    output logic            done,
    output logic            cs,
    output logic            ck,
    input  logic            miso,
    output logic            mosi
);

    localparam int TMAX = (SLOT > GAP) ? SLOT : GAP;
    localparam int TW   = $clog2(TMAX + 1);

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_tick;
    logic [TW-1:0]   w_tick_nx;
    logic            r_armed;
    logic [23:0]     r_addr;
    logic [LENW-1:0] r_rem;
    logic            r_sel;
    logic            r_last;
    logic [1:0]      r_gnt;
    logic            r_busy;
    logic [7:0]      r_q;
    logic            r_valid;
    logic            r_cs;
    logic            r_done;

    logic            w_sel;
    logic [23:0]     w_addr;
    logic [LENW-1:0] w_len;
    logic            w_grant;
    logic            w_tx;
    logic            w_rx;
    logic            w_arm;
    logic            w_cap;
    logic            w_accept;
    logic [7:0]      w_d;
    logic [7:0]      w_spi_q;

    // The requester not granted last wins a tie.
    always_comb begin
        w_sel = req[1];
        if (req == 2'b11) begin
            w_sel = ~r_last;
        end
        w_addr = w_sel ? addr1 : addr0;
        w_len  = w_sel ? len1  : len0;
    end

    assign w_accept = r_valid & ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_tick_nx = r_tick;
        w_grant   = 1'b0;
        w_tx      = 1'b0;
        w_rx      = 1'b0;
        w_arm     = 1'b0;
        w_cap     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (pe && (req != 2'b00)) begin
                    w_grant   = 1'b1;
                    w_tick_nx = '0;
                    w_next    = (w_len == '0) ? S_END : S_GAP;
                end
            end
            S_GAP: begin
                if (pe) begin
                    if (r_tick == TW'(GAP - 1)) begin
                        w_tick_nx = '0;
                        w_next    = S_CMD;
                    end else begin
                        w_tick_nx = r_tick + TW'(1);
                    end
                end
            end
            S_CMD, S_A2, S_A1, S_A0: begin
                if (pe) begin
                    w_tx = (r_tick == TW'(TICK_STROBE));
                    if (r_tick == TW'(SLOT - 1)) begin
                        w_tick_nx = '0;
                        case (r_state)
                            S_CMD:   w_next = S_A2;
                            S_A2:    w_next = S_A1;
                            S_A1:    w_next = S_A0;
                            default: w_next = S_DATA;
                        endcase
                    end else begin
                        w_tick_nx = r_tick + TW'(1);
                    end
                end
            end
            S_DATA: begin
                // The byte is complete on the first tick of the slot after its strobe.
                if (pe) begin
                    if (r_armed) begin
                        if (r_tick == TW'(TICK_SAMPLE)) begin
                            w_cap  = 1'b1;
                            w_next = S_HOLD;
                        end
                    end else begin
                        w_rx = (r_tick == TW'(TICK_STROBE));
                        if (r_tick == TW'(SLOT - 1)) begin
                            w_tick_nx = '0;
                            w_arm     = 1'b1;
                        end else begin
                            w_tick_nx = r_tick + TW'(1);
                        end
                    end
                end
            end
            S_HOLD: begin
                if (w_accept) begin
                    if (r_rem == '0) begin
                        w_next = S_END;
                    end else if ((req & r_gnt) != 2'b00) begin
                        w_next = S_DATA;
                    end else begin
                        w_next = S_END;
                    end
                end
            end
            S_END: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        case (r_state)
            S_CMD:   w_d = FLASH_READ;
            S_A2:    w_d = r_addr[23:16];
            S_A1:    w_d = r_addr[15:8];
            S_A0:    w_d = r_addr[7:0];
            default: w_d = 8'h00;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tick  <= '0;
            r_armed <= 1'b0;
            r_addr  <= '0;
            r_rem   <= '0;
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
            r_gnt   <= 2'b00;
            r_busy  <= 1'b0;
            r_q     <= 8'h00;
            r_valid <= 1'b0;
            r_cs    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_tick <= w_tick_nx;
            r_cs   <= !cs_asserted(w_next);
            r_done <= (w_next == S_END);
            if (w_arm) begin
                r_armed <= 1'b1;
            end else if (w_cap) begin
                r_armed <= 1'b0;
            end
            if (w_grant) begin
                r_addr <= w_addr;
                r_rem  <= w_len;
                r_sel  <= w_sel;
                r_gnt  <= w_sel ? 2'b10 : 2'b01;
                r_busy <= 1'b1;
            end
            if (w_cap) begin
                r_q     <= w_spi_q;
                r_valid <= 1'b1;
                r_rem   <= r_rem - LENW'(1);
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
            if (r_state == S_END) begin
                r_gnt  <= 2'b00;
                r_busy <= 1'b0;
                r_last <= r_sel;
            end
        end
    end

    flash_read_arbiter_spi Flash (
        .i_clock (clock),
        .i_reset (reset),
        .i_ce    (ne),
        .i_tx    (w_tx),
        .i_rx    (w_rx),
        .i_d     (w_d),
        .o_q     (w_spi_q),
        .o_ck    (ck),
        .o_mosi  (mosi),
        .i_miso  (miso)
    );

    assign gnt   = r_gnt;
    assign busy  = r_busy;
    assign q     = r_q;
    assign valid = r_valid;
    assign done  = r_done;
    assign cs    = r_cs;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter with a behavioural SPI flash model.
module tb_flash_read_arbiter;

    localparam int LENW = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            pe = 1'b0;
    logic            ne = 1'b0;
    logic [1:0]      req = 2'b00;
    logic [23:0]     addr0 = '0;
    logic [LENW-1:0] len0 = '0;
    logic [23:0]     addr1 = '0;
    logic [LENW-1:0] len1 = '0;
    logic            ready = 1'b0;
    logic            miso = 1'b0;
    logic [1:0]      gnt;
    logic            busy;
    logic [7:0]      q;
    logic            valid;
    logic            done;
    logic            cs;
    logic            ck;
    logic            mosi;

    flash_read_arbiter #(.SLOT(16), .GAP(14), .LENW(LENW)) dut (
        .clock (clock),
        .reset (reset),
        .pe    (pe),
        .ne    (ne),
        .req   (req),
        .addr0 (addr0),
        .len0  (len0),
        .addr1 (addr1),
        .len1  (len1),
        .gnt   (gnt),
        .busy  (busy),
        .q     (q),
        .valid (valid),
        .ready (ready),
        .done  (done),
        .cs    (cs),
        .ck    (ck),
        .miso  (miso),
        .mosi  (mosi)
    );

    always #5 clock = ~clock;

    // pe and ne alternate clock by clock.
    initial begin
        forever begin
            @(negedge clock);
            pe = ~pe;
            ne = ~pe;
        end
    end

    // Flash: samples mosi on ck rise, shifts data out on ck fall after 32 command bits.
    logic [7:0]  fdata [0:15];
    int          bitcnt = 0;
    logic [31:0] cmd = '0;

    always @(posedge ck or posedge cs) begin
        if (cs) begin
            bitcnt = 0;
        end else begin
            if (bitcnt < 32) cmd = {cmd[30:0], mosi};
            bitcnt = bitcnt + 1;
        end
    end

    always @(negedge ck) begin
        if (!cs && bitcnt >= 32) begin
            miso = fdata[((bitcnt - 32) >> 3) & 15][7 - ((bitcnt - 32) & 7)];
        end
    end

    logic [7:0] rxq [$];
    int n_done = 0;
    int n_cslow = 0;
    int n_gap = 0;

    always @(negedge clock) begin
        if (valid && ready) rxq.push_back(q);
        if (done) n_done++;
        if (!cs) n_cslow++;
        if (busy && cs && !done) n_gap++;
    end

    int vecs = 0;
    int errs = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clk(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic cond(input int sel);
        case (sel)
            0:       return done;
            1:       return busy && !done;
            2:       return valid;
            default: return !cs;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string tag);
        int k;
        k = 0;
        while (!cond(sel) && k < 4000) begin
            clk(1);
            k++;
        end
        check(tag, {31'd0, cond(sel)}, 32'd1);
    endtask

    function automatic logic [7:0] rx_at(input int i);
        if (i < rxq.size()) return rxq[i];
        return 8'hxx;
    endfunction

    int b_q, b_cs, b_gap, b_done;

    task automatic mark();
        b_q    = rxq.size();
        b_cs   = n_cslow;
        b_gap  = n_gap;
        b_done = n_done;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) fdata[i] = 8'h00;
        clk(3);
        check("rst_cs",    {31'd0, cs},    32'd1);
        check("rst_gnt",   {30'd0, gnt},   32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_q",     {24'd0, q},     32'd0);
        check("rst_ck",    {31'd0, ck},    32'd0);

        // Single request of three bytes
        fdata[0] = 8'hA5; fdata[1] = 8'h5A; fdata[2] = 8'hC3;
        addr0 = 24'h704D00; len0 = 16'd3; ready = 1'b1; req = 2'b01;
        mark();
        reset = 1'b0;
        wait_for(1, "t1_busy");
        check("t1_gnt", {30'd0, gnt}, 32'd1);
        wait_for(0, "t1_done");
        req = 2'b00;
        clk(3);
        check("t1_nbytes", rxq.size() - b_q, 32'd3);
        check("t1_b0", {24'd0, rx_at(b_q)},     32'hA5);
        check("t1_b1", {24'd0, rx_at(b_q + 1)}, 32'h5A);
        check("t1_b2", {24'd0, rx_at(b_q + 2)}, 32'hC3);
        check("t1_cmd", cmd, 32'h03704D00);
        check("t1_ndone", n_done - b_done, 32'd1);
        check("t1_cslow", n_cslow - b_cs, 32'd231);
        check("t1_gap", n_gap - b_gap, 32'd28);

        // Contention from reset: 01, then 10, then 01
        reset = 1'b1;
        clk(2);
        len0 = 16'd1; len1 = 16'd1; req = 2'b11;
        reset = 1'b0;
        wait_for(1, "t2_busy_a");
        check("t2_gnt_a", {30'd0, gnt}, 32'd1);
        wait_for(0, "t2_done_a");
        clk(1);
        wait_for(1, "t2_busy_b");
        check("t2_gnt_b", {30'd0, gnt}, 32'd2);
        wait_for(0, "t2_done_b");
        clk(1);
        wait_for(1, "t2_busy_c");
        check("t2_gnt_c", {30'd0, gnt}, 32'd1);
        wait_for(0, "t2_done_c");
        req = 2'b00;
        clk(3);

        // Back-pressure on the first byte
        fdata[0] = 8'hA5; fdata[1] = 8'h5A;
        len0 = 16'd2; ready = 1'b0; req = 2'b01;
        mark();
        wait_for(2, "t3_valid");
        check("t3_q0", {24'd0, q}, 32'hA5);
        for (int i = 0; i < 100; i++) begin
            clk(1);
            check("t3_hold", {21'd0, valid, q, ck, cs}, {21'd0, 1'b1, 8'hA5, 1'b0, 1'b0});
        end
        ready = 1'b1;
        wait_for(0, "t3_done");
        req = 2'b00;
        clk(3);
        check("t3_nbytes", rxq.size() - b_q, 32'd2);
        check("t3_b0", {24'd0, rx_at(b_q)},     32'hA5);
        check("t3_b1", {24'd0, rx_at(b_q + 1)}, 32'h5A);

        // Zero-length request
        mark();
        len1 = 16'd0; req = 2'b10;
        wait_for(0, "t4_done");
        check("t4_gnt", {30'd0, gnt}, 32'd2);
        check("t4_busy", {31'd0, busy}, 32'd1);
        req = 2'b00;
        clk(3);
        check("t4_cslow", n_cslow - b_cs, 32'd0);
        check("t4_ndone", n_done - b_done, 32'd1);
        check("t4_idle", {29'd0, busy, gnt}, 32'd0);

        // Withdrawal while the third byte is pending
        for (int i = 0; i < 10; i++) fdata[i] = 8'((i + 1) * 8'h11);
        len1 = 16'd10; ready = 1'b0; req = 2'b10;
        mark();
        for (int b = 0; b < 3; b++) begin
            wait_for(2, "t5_valid");
            check("t5_q", {24'd0, q}, {24'd0, 8'((b + 1) * 8'h11)});
            if (b == 2) req = 2'b00;
            ready = 1'b1;
            clk(1);
            ready = 1'b0;
        end
        wait_for(0, "t5_done");
        clk(3);
        check("t5_nbytes", rxq.size() - b_q, 32'd3);
        check("t5_b2", {24'd0, rx_at(b_q + 2)}, 32'h33);
        check("t5_end", {30'd0, cs, valid}, 32'd2);

        // Reset in the middle of the address phase
        fdata[0] = 8'hA5; fdata[1] = 8'h5A;
        addr0 = 24'h123456; len0 = 16'd2; ready = 1'b1; req = 2'b01;
        wait_for(3, "t6_cslow");
        clk(70);
        reset = 1'b1;
        #1;
        check("t6_rst", {28'd0, cs, busy, gnt}, 32'h8);
        clk(3);
        mark();
        reset = 1'b0;
        wait_for(0, "t6_done");
        req = 2'b00;
        clk(3);
        check("t6_nbytes", rxq.size() - b_q, 32'd2);
        check("t6_b0", {24'd0, rx_at(b_q)},     32'hA5);
        check("t6_b1", {24'd0, rx_at(b_q + 1)}, 32'h5A);
        check("t6_cmd", cmd, 32'h03123456);
        check("t6_cslow", n_cslow - b_cs, 32'd197);
        check("t6_gap", n_gap - b_gap, 32'd28);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
